// File: rtl/fpu_ss_pkg.sv
// Shared FPU-subsystem types: memory-op metadata pushed by the issue logic
// and the per-entry record held by the memory tracking buffer.
package fpu_ss_pkg;

    localparam int unsigned MEM_ID_W   = 4;
    localparam int unsigned FPR_ADDR_W = 5;
    localparam int unsigned MEM_DATA_W = 32;

    // we=1: load into FP rd; we=0: store (no writeback)
    typedef struct packed {
        logic [MEM_ID_W-1:0]   id;
        logic [FPR_ADDR_W-1:0] rd;
        logic                  we;
    } mem_metadata_t;

    typedef struct packed {
        mem_metadata_t         meta;
        logic [MEM_DATA_W-1:0] rdata;
        logic                  err;
    } mem_entry_t;

endpackage

// File: rtl/fpu_ss_mem_buffer_if.sv
// Handshake bundle between the FPU memory buffer, the issue logic, the
// CV-X-IF memory result channel and the FP register-file writeback port.
interface fpu_ss_mem_buffer_if;

    logic                              push_valid_i;
    logic                              push_ready_o;
    fpu_ss_pkg::mem_metadata_t         push_meta_i;

    logic                              mem_result_valid_i;
    logic [fpu_ss_pkg::MEM_ID_W-1:0]   mem_result_id_i;
    logic [fpu_ss_pkg::MEM_DATA_W-1:0] mem_result_rdata_i;
    logic                              mem_result_err_i;

    logic                              fpr_wb_valid_o;
    logic                              fpr_wb_ready_i;
    logic [fpu_ss_pkg::FPR_ADDR_W-1:0] fpr_wb_addr_o;
    logic [fpu_ss_pkg::MEM_DATA_W-1:0] fpr_wb_data_o;

    logic                              mem_err_o;
    logic [fpu_ss_pkg::MEM_ID_W-1:0]   mem_err_id_o;
    logic                              protocol_err_o;

    modport master (
        output push_valid_i, push_meta_i,
        output mem_result_valid_i, mem_result_id_i, mem_result_rdata_i, mem_result_err_i,
        output fpr_wb_ready_i,
        input  push_ready_o,
        input  fpr_wb_valid_o, fpr_wb_addr_o, fpr_wb_data_o,
        input  mem_err_o, mem_err_id_o, protocol_err_o
    );

    modport slave (
        input  push_valid_i, push_meta_i,
        input  mem_result_valid_i, mem_result_id_i, mem_result_rdata_i, mem_result_err_i,
        input  fpr_wb_ready_i,
        output push_ready_o,
        output fpr_wb_valid_o, fpr_wb_addr_o, fpr_wb_data_o,
        output mem_err_o, mem_err_id_o, protocol_err_o
    );

endinterface

// File: rtl/fpu_ss_mem_buffer.sv
// In-order tracking buffer for FLW/FSW: matches memory results to issued ops,
// writes load data back to the FP regfile and answers pending-rd queries.
module fpu_ss_mem_buffer
    import fpu_ss_pkg::*;
#(
    parameter int unsigned DEPTH = 4   // power of two, >= 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    fpu_ss_mem_buffer_if.slave        bus,
    input  logic [FPR_ADDR_W-1:0]     query_rd_i,
    output logic                      rd_pending_o,
    output logic                      empty_o,
    output logic [$clog2(DEPTH):0]    outstanding_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] wr_ptr_q, rsp_ptr_q, rd_ptr_q;
    logic [PW-1:0] count;
    logic [AW-1:0] wr_idx, rsp_idx, rd_idx;

    mem_entry_t    mem_q [DEPTH];
    mem_entry_t    head;
    mem_metadata_t rsp_meta;

    logic full;
    logic awaiting_rsp;
    logic head_answered;
    logic push_fire;
    logic result_match;
    logic result_bad;
    logic head_is_load;
    logic wb_valid;
    logic retire;
    logic retire_err;

    logic                mem_err_q;
    logic [MEM_ID_W-1:0] mem_err_id_q;
    logic                protocol_err_q;

    assign wr_idx  = wr_ptr_q[AW-1:0];
    assign rsp_idx = rsp_ptr_q[AW-1:0];
    assign rd_idx  = rd_ptr_q[AW-1:0];

    assign count         = wr_ptr_q - rd_ptr_q;
    assign full          = (count == DEPTH_P);
    assign awaiting_rsp  = (wr_ptr_q != rsp_ptr_q);
    assign head_answered = (rsp_ptr_q != rd_ptr_q);

    assign head     = mem_q[rd_idx];
    assign rsp_meta = mem_q[rsp_idx].meta;

    assign push_fire    = bus.push_valid_i && !full;
    // Results only match entries pushed in an earlier cycle, since the
    // awaiting check uses the registered write pointer.
    assign result_match = bus.mem_result_valid_i && awaiting_rsp &&
                          (bus.mem_result_id_i == rsp_meta.id);
    assign result_bad   = bus.mem_result_valid_i && !result_match;

    // Errored loads and stores retire on their own; clean loads wait for the regfile.
    assign head_is_load = head.meta.we && !head.err;
    assign wb_valid     = head_answered && head_is_load;
    assign retire       = head_answered && (!head_is_load || bus.fpr_wb_ready_i);
    assign retire_err   = head_answered && head.err;

    assign bus.push_ready_o   = !full;
    assign bus.fpr_wb_valid_o = wb_valid;
    assign bus.fpr_wb_addr_o  = wb_valid ? head.meta.rd : '0;
    assign bus.fpr_wb_data_o  = wb_valid ? head.rdata   : '0;
    assign bus.mem_err_o      = mem_err_q;
    assign bus.mem_err_id_o   = mem_err_id_q;
    assign bus.protocol_err_o = protocol_err_q;

    assign empty_o       = (count == '0);
    assign outstanding_o = count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q       <= '0;
            rsp_ptr_q      <= '0;
            rd_ptr_q       <= '0;
            mem_err_q      <= 1'b0;
            mem_err_id_q   <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            if (push_fire) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (result_match) begin
                rsp_ptr_q <= rsp_ptr_q + PW'(1);
            end
            if (retire) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            mem_err_q      <= retire_err;
            mem_err_id_q   <= retire_err ? head.meta.id : '0;
            protocol_err_q <= result_bad;
        end
    end

    // Entry storage needs no reset: liveness is defined purely by the pointers.
    // Push and result never target the same slot (that would need wr == rsp).
    always_ff @(posedge clk_i) begin
        if (push_fire) begin
            mem_q[wr_idx].meta <= bus.push_meta_i;
        end
        if (result_match) begin
            mem_q[rsp_idx].rdata <= bus.mem_result_rdata_i;
            mem_q[rsp_idx].err   <= bus.mem_result_err_i;
        end
    end

    // Scan live slots [rd_ptr, wr_ptr) for a load targeting the queried register.
    always_comb begin
        rd_pending_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((PW'(i) < count) &&
                mem_q[rd_idx + AW'(i)].meta.we &&
                (mem_q[rd_idx + AW'(i)].meta.rd == query_rd_i)) begin
                rd_pending_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_ss_mem_buffer.sv
// Directed plus randomized bench for fpu_ss_mem_buffer, checked against a
// queue-based model of outstanding memory operations.
module tb_fpu_ss_mem_buffer;
    import fpu_ss_pkg::*;

    localparam int DEPTH = 4;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] query_rd;
    logic       rd_pending;
    logic       empty;
    logic [2:0] outstanding;

    fpu_ss_mem_buffer_if bus ();

    fpu_ss_mem_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .bus           (bus),
        .query_rd_i    (query_rd),
        .rd_pending_o  (rd_pending),
        .empty_o       (empty),
        .outstanding_o (outstanding)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        mem_metadata_t meta;
        bit            ans;
        logic [31:0]   rdata;
        bit            err;
    } mrec_t;

    mrec_t      mq[$];
    int         passed = 0;
    int         failed = 0;
    int         total  = 0;
    bit         exp_merr = 0;
    bit         exp_perr = 0;
    logic [3:0] exp_merr_id = '0;

    function automatic mem_metadata_t mk(input int id, input int rd, input bit we);
        mem_metadata_t m;
        m.id = 4'(id);
        m.rd = 5'(rd);
        m.we = we;
        return m;
    endfunction

    function automatic int n_answered();
        int n = 0;
        while (n < mq.size() && mq[n].ans) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int          na;
        bit          wbv;
        bit          pend;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        na = n_answered();
        wbv = 0;
        exp_addr = '0;
        exp_data = '0;
        if (na > 0) begin
            if (!mq[0].err && mq[0].meta.we) begin
                wbv = 1;
                exp_addr = mq[0].meta.rd;
                exp_data = mq[0].rdata;
            end
        end
        pend = 0;
        foreach (mq[i]) if (mq[i].meta.we && mq[i].meta.rd == query_rd) pend = 1;
        chk("push_ready",   32'(bus.push_ready_o),   32'(mq.size() < DEPTH));
        chk("empty",        32'(empty),              32'(mq.size() == 0));
        chk("outstanding",  32'(outstanding),        32'(mq.size()));
        chk("wb_valid",     32'(bus.fpr_wb_valid_o), 32'(wbv));
        chk("wb_addr",      32'(bus.fpr_wb_addr_o),  32'(exp_addr));
        chk("wb_data",      bus.fpr_wb_data_o,       exp_data);
        chk("mem_err",      32'(bus.mem_err_o),      32'(exp_merr));
        chk("mem_err_id",   32'(bus.mem_err_id_o),   32'(exp_merr_id));
        chk("protocol_err", 32'(bus.protocol_err_o), 32'(exp_perr));
        chk("rd_pending",   32'(rd_pending),         32'(pend));
    endtask

    // One clock cycle: drive, check current outputs, advance model, clock.
    task automatic step(input bit pv, input mem_metadata_t pm, input bit rv,
                        input logic [3:0] rid, input logic [31:0] rdat, input bit rerr,
                        input bit rdy, input logic [4:0] q);
        int         na;
        bit         do_pop, push_ok, merr_n, perr_n;
        logic [3:0] merr_id_n;
        bus.push_valid_i       = pv;
        bus.push_meta_i        = pm;
        bus.mem_result_valid_i = rv;
        bus.mem_result_id_i    = rid;
        bus.mem_result_rdata_i = rdat;
        bus.mem_result_err_i   = rerr;
        bus.fpr_wb_ready_i     = rdy;
        query_rd               = q;
        #1;
        check_outputs();
        na = n_answered();
        do_pop = 0; merr_n = 0; merr_id_n = '0; perr_n = 0;
        push_ok = pv && (mq.size() < DEPTH);
        if (na > 0) begin
            if (mq[0].err) begin
                do_pop = 1; merr_n = 1; merr_id_n = mq[0].meta.id;
            end else if (!mq[0].meta.we || rdy) begin
                do_pop = 1;
            end
        end
        if (rv) begin
            if (na < mq.size() && mq[na].meta.id == rid) begin
                mq[na].ans = 1; mq[na].rdata = rdat; mq[na].err = rerr;
            end else begin
                perr_n = 1;
            end
        end
        if (do_pop) void'(mq.pop_front());
        if (push_ok) mq.push_back('{pm, 1'b0, 32'h0, 1'b0});
        exp_merr = merr_n; exp_merr_id = merr_id_n; exp_perr = perr_n;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input bit rdy, input logic [4:0] q);
        step(0, mk(0, 0, 0), 0, 4'h0, 32'h0, 0, rdy, q);
    endtask

    task automatic result(input int id, input logic [31:0] d, input bit e, input bit rdy, input logic [4:0] q);
        step(0, mk(0, 0, 0), 1, 4'(id), d, e, rdy, q);
    endtask

    task automatic do_reset();
        rst_i = 1;
        bus.push_valid_i = 0; bus.mem_result_valid_i = 0; bus.fpr_wb_ready_i = 0;
        @(posedge clk_i);
        #1;
        mq.delete();
        exp_merr = 0; exp_merr_id = '0; exp_perr = 0;
        check_outputs();
        rst_i = 0;
    endtask

    initial begin
        bit            pv, rv, rerr, rdy;
        mem_metadata_t pm;
        logic [3:0]    rid;
        logic [4:0]    q;
        int            na;
        int            next_id;

        rst_i = 1;
        query_rd = '0;
        bus.push_valid_i = 0; bus.push_meta_i = '0;
        bus.mem_result_valid_i = 0; bus.mem_result_id_i = '0;
        bus.mem_result_rdata_i = '0; bus.mem_result_err_i = 0;
        bus.fpr_wb_ready_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_push_ready", 32'(bus.push_ready_o), 32'd1);
        chk("reset_empty", 32'(empty), 32'd1);
        check_outputs();
        rst_i = 0;

        // load then result
        step(1, mk(3, 7, 1), 0, 4'h0, 32'h0, 0, 1, 5'd7);
        result(3, 32'h3F80_0000, 0, 1, 5'd7);
        chk("load_wb_valid", 32'(bus.fpr_wb_valid_o), 32'd1);
        chk("load_wb_addr", 32'(bus.fpr_wb_addr_o), 32'd7);
        chk("load_wb_data", bus.fpr_wb_data_o, 32'h3F80_0000);
        idle(1, 5'd7);
        chk("load_empty", 32'(empty), 32'd1);

        // store
        step(1, mk(1, 4, 0), 0, 4'h0, 32'h0, 0, 1, 5'd4);
        result(1, 32'hDEAD_BEEF, 0, 1, 5'd4);
        idle(1, 5'd4);
        chk("store_outstanding", 32'(outstanding), 32'd0);

        // full and backpressure
        for (int i = 0; i < DEPTH; i++) step(1, mk(i, 10 + i, 1), 0, 4'h0, 32'h0, 0, 0, 5'd10);
        chk("full_push_ready", 32'(bus.push_ready_o), 32'd0);
        step(1, mk(9, 20, 1), 0, 4'h0, 32'h0, 0, 0, 5'd20);
        for (int i = 0; i < DEPTH; i++) result(i, $urandom, 0, 0, 5'd11);
        for (int i = 0; i < DEPTH; i++) begin
            chk("full_wb_order", 32'(bus.fpr_wb_addr_o), 32'(10 + i));
            idle(1, 5'd12);
            if (i == 0) chk("full_ready_after_retire", 32'(bus.push_ready_o), 32'd1);
        end

        // bus error on load, then protocol errors
        step(1, mk(5, 3, 1), 0, 4'h0, 32'h0, 0, 1, 5'd3);
        result(5, 32'h1234_5678, 1, 1, 5'd3);
        chk("err_no_wb", 32'(bus.fpr_wb_valid_o), 32'd0);
        idle(1, 5'd3);
        chk("err_pulse", 32'(bus.mem_err_o), 32'd1);
        chk("err_pulse_id", 32'(bus.mem_err_id_o), 32'd5);
        result(2, 32'h0, 0, 1, 5'd0);
        chk("perr_empty", 32'(bus.protocol_err_o), 32'd1);
        chk("perr_empty_cnt", 32'(outstanding), 32'd0);
        step(1, mk(6, 8, 1), 1, 4'h6, 32'hAAAA_0000, 0, 0, 5'd8);
        chk("perr_same_cycle", 32'(bus.protocol_err_o), 32'd1);
        result(7, 32'h0, 0, 0, 5'd8);
        chk("perr_bad_id", 32'(bus.protocol_err_o), 32'd1);
        chk("perr_bad_id_cnt", 32'(outstanding), 32'd1);
        result(6, 32'hBBBB_0001, 0, 0, 5'd8);
        idle(1, 5'd8);
        idle(1, 5'd8);

        // scoreboard query
        step(1, mk(8, 2, 1), 0, 4'h0, 32'h0, 0, 0, 5'd2);
        step(1, mk(9, 9, 1), 0, 4'h0, 32'h0, 0, 0, 5'd9);
        query_rd = 5'd2; #1; chk("sb_q2", 32'(rd_pending), 32'd1);
        query_rd = 5'd9; #1; chk("sb_q9", 32'(rd_pending), 32'd1);
        query_rd = 5'd4; #1; chk("sb_q4", 32'(rd_pending), 32'd0);
        result(8, 32'h11, 0, 0, 5'd2);
        result(9, 32'h22, 0, 1, 5'd2);
        idle(1, 5'd9);
        query_rd = 5'd2; #1; chk("sb_q2_clear", 32'(rd_pending), 32'd0);
        idle(1, 5'd9);
        idle(1, 5'd9);

        // randomized interleaving across many wraps, with a mid-stream reset
        next_id = 0;
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                do_reset();
                result(0, 32'h0, 0, 1, 5'd0);
                continue;
            end
            pv   = $urandom_range(0, 1) == 1;
            pm   = mk(next_id, $urandom_range(0, 7), $urandom_range(0, 1) == 1);
            na   = n_answered();
            rv   = $urandom_range(0, 9) < 7;
            if (na < mq.size() && $urandom_range(0, 9) < 8) rid = mq[na].meta.id;
            else rid = 4'($urandom_range(0, 15));
            rerr = $urandom_range(0, 7) == 0;
            rdy  = $urandom_range(0, 1) == 1;
            q    = 5'($urandom_range(0, 7));
            if (pv && mq.size() < DEPTH) next_id = (next_id + 1) % 16;
            step(pv, pm, rv, rid, $urandom, rerr, rdy, q);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fpu_ss_mem_buffer.md
# fpu_ss_mem_buffer

In-order tracking buffer for FPU-subsystem memory operations (FLW/FSW) issued over the CV-X-IF memory interface. Sits directly downstream of the FPU subsystem decoder/issue logic, which pushes one `mem_metadata_t` record per accepted memory request. It matches in-order memory results to those records, stores load data, and writes load results back to the FP register file through a valid/ready port. It also exposes a pending-destination query for the FP scoreboard.

## Interface
Parameters:
- `DEPTH`, 4: number of outstanding memory operations; power of two, ≥ 2.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `push_valid_i` in 1: new memory op issued.
- `push_ready_o` out 1: buffer can accept; equals `!full`.
- `push_meta_i` in `mem_metadata_t`: {id[3:0], rd[4:0], we}; `we`=1 for a load to FP rd, `we`=0 for a store.
- `mem_result_valid_i` in 1: memory result; no backpressure.
- `mem_result_id_i` in 4: id of the result.
- `mem_result_rdata_i` in 32: load data.
- `mem_result_err_i` in 1: bus error.
- `fpr_wb_valid_o` out 1: load writeback request.
- `fpr_wb_ready_i` in 1: regfile accepts the writeback.
- `fpr_wb_addr_o` out 5: FP destination register.
- `fpr_wb_data_o` out 32: load data.
- `mem_err_o` out 1: one-cycle pulse on an errored result.
- `mem_err_id_o` out 4: id of the errored op.
- `protocol_err_o` out 1: one-cycle pulse on an unexpected or mismatched result.
- `query_rd_i` in 5: FP register to check.
- `rd_pending_o` out 1: some live entry with `we`=1 targets `query_rd_i` (combinational).
- `empty_o` out 1: no live entries.
- `outstanding_o` out `$clog2(DEPTH)+1`: number of live entries.

## Operation
- Storage: circular array of DEPTH entries. Each entry holds {meta, rdata, err}.
- Three pointers, each `$clog2(DEPTH)+1` bits wide, wrapping naturally:
  - `wr_ptr`: advanced by push.
  - `rsp_ptr`: advanced by result.
  - `rd_ptr`: advanced by retire.
- Invariant: `rd_ptr ≤ rsp_ptr ≤ wr_ptr`, modulo wrap.
- Derived flags:
  - full: `wr_ptr - rd_ptr == DEPTH`.
  - awaiting response: `wr_ptr != rsp_ptr`.
  - head answered: `rsp_ptr != rd_ptr`.
- Push: when `push_valid_i && push_ready_o`, write meta at `wr_ptr` and increment it. `push_ready_o` depends only on full, so no push is accepted in a full cycle even if a pop occurs.
- Result, when `mem_result_valid_i`:
  - If no entry is awaiting a response, or `mem_result_id_i` ≠ id at `rsp_ptr`: pulse `protocol_err_o`; no state change.
  - Otherwise: store rdata and err at `rsp_ptr` and increment it.
- Retire, when the head is answered:
  - err=1: retire without writeback; pulse `mem_err_o` with the head id.
  - err=0, we=0 (store): retire silently.
  - err=0, we=1 (load): drive `fpr_wb_valid_o`; retire on `fpr_wb_ready_i`.
  - At most one retire per cycle.
- `rd_pending_o` covers every entry in `[rd_ptr, wr_ptr)` with `we`=1, including answered loads still waiting for writeback. Errored loads count until retired.

## Timing
- Reset:
  - All pointers = 0; all entries invalid.
  - `push_ready_o`=1, `empty_o`=1, `outstanding_o`=0.
  - `fpr_wb_valid_o`=0, `fpr_wb_addr_o`=0, `fpr_wb_data_o`=0.
  - `mem_err_o`=0, `mem_err_id_o`=0, `protocol_err_o`=0.
  - A reset mid-operation drops all entries; results arriving afterwards are protocol errors.
- Latency:
  - Push at cycle N: the entry can be answered from N+1. A result in the same cycle as its own push is a protocol error.
  - Result at cycle N: `fpr_wb_valid_o` or `mem_err_o` asserted at N+1 at the earliest.
- Throughput: one push, one result and one retire per cycle, all simultaneously.
- `fpr_wb_valid_o` follows valid/ready rules: once asserted, it and addr/data stay stable until `fpr_wb_ready_i`.
- `mem_err_o`, `mem_err_id_o` and `protocol_err_o` are registered single-cycle pulses.
- `outstanding_o` is updated one cycle after a push or retire.

## Structure
- Reuse `mem_metadata_t` from `fpu_ss_pkg`.
- Add `fpu_ss_pkg::mem_entry_t` {meta, rdata[31:0], err} to the same package.
- Single module; no sub-module.

## Test plan
- Load then result: push {id=3, rd=7, we=1}; result id=3, data=0x3F800000 at N → at N+1, wb valid with addr=7, data=0x3F800000; with ready=1, retired and `empty_o`=1 at N+2.
- Store: push {id=1, we=0}; result id=1 → no writeback, `outstanding_o` returns to 0, `rd_pending_o`=0 throughout.
- Full and backpressure: DEPTH=4, push 4 loads with `fpr_wb_ready_i`=0 → `push_ready_o`=0; answer all 4; release ready → 4 writebacks in push order; `push_ready_o`=1 after the first retire.
- Errors: result with err=1 on load id=5 → `mem_err_o` pulse with id 5, no writeback. A result while empty, or with id≠head-pending id, → `protocol_err_o` pulse, counters unchanged.
- Scoreboard: pending loads to rd=2 and rd=9 → `rd_pending_o`=1 for queries 2 and 9, 0 for 4; each clears after its writeback.
- Wrap and reset: 3×DEPTH interleaved push/result/retire with random ready → correct order across wrap. Assert reset mid-stream → all outputs at reset values next cycle.
